led_arbiter: RTL and testbench



---
 rtl/led_arbiter.sv | 156 +++++++++++++++
 tb/tb_led_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_arbiter.sv
// Round-robin owner of the 8-bit user LED bank, with a minimum hold time before preemption.
// Define LED_ARBITER_HEARTBEAT_EN to show a free-running heartbeat on the LEDs when idle.
module led_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HB_BITS     = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [7:0]               led,
    output logic                     busy
);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(N_REQ - 1);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_last;
    logic [HOLD_W-1:0]   r_hold;
    logic [7:0]          r_led;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [ID_W-1:0]     w_owner_nxt;
    logic                w_load;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [N_REQ-1:0]    w_others;
    logic [N_REQ-1:0]    w_grant_nxt;
    logic                w_busy_nxt;
    logic [7:0]          w_led_nxt;
    logic [7:0]          w_idle_pat;

    // First set bit of mask, scanning after+1, after+2, ... modulo N_REQ.
    function automatic logic [ID_W-1:0] f_pick(input logic [N_REQ-1:0] mask,
                                               input logic [ID_W-1:0]  after);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = after;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(after) + i) % N_REQ;
            if (!found && mask[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef LED_ARBITER_HEARTBEAT_EN
    logic [HB_BITS-1:0] r_hb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hb <= '0;
        end else begin
            r_hb <= r_hb + HB_BITS'(1);
        end
    end

    assign w_idle_pat = r_hb[HB_BITS-1 -: 8];
`else
    assign w_idle_pat = 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last     <= LAST_RST;
            r_hold     <= '0;
            r_led      <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_owner_nxt;
            r_hold     <= w_hold_nxt;
            r_led      <= w_led_nxt;
            r_busy     <= w_busy_nxt;
            if (w_load) begin
                r_last <= w_owner_nxt;
            end
        end
    end

    // The owner is masked out so that preemption always moves to someone else.
    assign w_others = req & ~r_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_grant_id;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_OWNED;
                    w_owner_nxt = f_pick(req, r_last);
                    w_load      = 1'b1;
                end
            end
            S_OWNED: begin
                if (!req[r_grant_id]) begin
                    if (|w_others) begin
                        w_owner_nxt = f_pick(w_others, r_last);
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if ((r_hold == '0) && (|w_others)) begin
                    w_owner_nxt = f_pick(w_others, r_last);
                    w_load      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_hold_nxt = HOLD_LOAD;
        end else if (r_hold == '0) begin
            w_hold_nxt = '0;
        end else begin
            w_hold_nxt = r_hold - HOLD_W'(1);
        end
    end

    // LED follows the current (registered) owner, so it lags grant by one cycle.
    always_comb begin
        w_grant_nxt = '0;
        w_busy_nxt  = (w_state_nxt == S_OWNED);
        if (w_state_nxt == S_OWNED) begin
            w_grant_nxt[w_owner_nxt] = 1'b1;
        end
        if (r_state == S_OWNED) begin
            w_led_nxt = data[int'(r_grant_id)*8 +: 8];
        end else begin
            w_led_nxt = w_idle_pat;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign led      = r_led;
    assign busy     = r_busy;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with N_REQ=4, HOLD_CYCLES=4, HB_BITS=8.
module tb_led_arbiter;
    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic [7:0]  led;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    led_arbiter #(
        .N_REQ      (4),
        .HOLD_CYCLES(4),
        .HB_BITS    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data    (data),
        .grant   (grant),
        .grant_id(grant_id),
        .led     (led),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] l0;
        reset = 1'b1;
        req   = 4'b0000;
        data  = 32'h0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        reset = 1'b0;

        // single request, live data, release to idle
        req  = 4'b0100;
        data = 32'h44A52211;
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_id", 32'(grant_id), 32'h2);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_led_lag", 32'(led), 32'h0);
        tick();
        chk("single_led", 32'(led), 32'hA5);
        data = 32'h443C2211;
        tick();
        chk("live_led", 32'(led), 32'h3C);
        req = 4'b0000;
        tick();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_id_hold", 32'(grant_id), 32'h2);
        chk("idle_led_last", 32'(led), 32'h3C);
        tick();
`ifdef LED_ARBITER_HEARTBEAT_EN
        l0 = led;
        tick();
        chk("hb_step", 32'(led), 32'(8'(l0 + 8'd1)));
`else
        chk("idle_led", 32'(led), 32'h0);
`endif

        // fair rotation, 4 cycles per owner
        do_reset();
        req = 4'b1111;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk($sformatf("rot_t%0d", t), 32'(grant), 32'(1) << (((t - 1) / 4) % 4));
        end

        // early release hands off without an idle cycle
        do_reset();
        req = 4'b1001;
        tick();
        chk("early_g1", 32'(grant), 32'h1);
        tick();
        chk("early_g2", 32'(grant), 32'h1);
        chk("early_busy2", 32'(busy), 32'h1);
        req = 4'b1000;
        tick();
        chk("early_hand", 32'(grant), 32'h8);
        chk("early_busy3", 32'(busy), 32'h1);
        chk("early_id", 32'(grant_id), 32'h3);

        // lone owner keeps the bank past the hold time
        do_reset();
        req = 4'b0010;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1 || t == 20) chk($sformatf("lone_t%0d", t), 32'(grant), 32'h2);
        end
        chk("lone_hold0", 32'(dut.r_hold), 32'h0);
        req = 4'b0011;
        tick();
        chk("lone_preempt", 32'(grant), 32'h1);
        chk("lone_preempt_id", 32'(grant_id), 32'h0);

        // asynchronous reset mid-grant
        do_reset();
        data = 32'h44332211;
        req  = 4'b1111;
        tick();
        tick();
        chk("async_pre_led", 32'(led), 32'h11);
        #2;
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_led", 32'(led), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        chk("async_first", 32'(grant), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
